// File: rtl/mag_pkg.sv
// Shared definitions for the magnetron SR-latch command generator.
// Holds the state encoding, default timing constants and a counter-width helper.
package mag_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_GUARD = 2'd2
    } mag_state_e;

    localparam int DEB_CYCLES_DEF   = 4;
    localparam int GUARD_CYCLES_DEF = 8;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a stable-count debouncer.
// FAST_LOW lets a synchronized 0 pass straight through (used for door opening).
module debounce_sync
    import mag_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter bit RST_LEVEL  = 1'b1,
    parameter bit FAST_LOW   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level
);

    localparam int            CW       = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // r_cnt holds how many consecutive samples have disagreed with r_level so far.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta  <= RST_LEVEL;
            r_sync  <= RST_LEVEL;
            r_level <= RST_LEVEL;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if ((FAST_LOW && !r_sync) || (r_cnt == CNT_LAST)) begin
                r_level <= r_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/mag_sr_driver.sv
// Conditions start/stop/door inputs, enforces interlocks and issues one-cycle
// S/R pulses to the magnetron latch; mag_on mirrors the commanded latch state.
module mag_sr_driver
    import mag_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int GUARD_CYCLES = GUARD_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic       timer_done,
    output logic       S,
    output logic       R,
    output logic       mag_on,
    output logic       busy,
    output mag_state_e o_dbg_state
);

    localparam int            GW         = cnt_width(GUARD_CYCLES);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    logic          w_start_lvl;
    logic          w_stop_lvl;
    logic          w_door_ok;
    logic          r_start_lvl_d;
    logic          r_stop_lvl_d;
    logic          w_start_stb;
    logic          w_stop_stb;
    mag_state_e    r_state;
    mag_state_e    w_state_nxt;
    logic [GW-1:0] r_guard_cnt;
    logic          w_set;
    logic          w_clr;
    logic          r_s;
    logic          r_r;
    logic          r_mag_on;
    logic          r_busy;

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES), .RST_LEVEL(1'b1), .FAST_LOW(1'b0)) u_start_deb (
        .i_clk(clk), .i_rst_n(reset_n), .i_raw(startn), .o_level(w_start_lvl)
    );

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES), .RST_LEVEL(1'b1), .FAST_LOW(1'b0)) u_stop_deb (
        .i_clk(clk), .i_rst_n(reset_n), .i_raw(stopn), .o_level(w_stop_lvl)
    );

    // Door opening bypasses the debounce; only closing has to prove itself stable.
    debounce_sync #(.DEB_CYCLES(DEB_CYCLES), .RST_LEVEL(1'b0), .FAST_LOW(1'b1)) u_door_deb (
        .i_clk(clk), .i_rst_n(reset_n), .i_raw(door_closed), .o_level(w_door_ok)
    );

    assign w_start_stb = r_start_lvl_d & ~w_start_lvl;
    assign w_stop_stb  = r_stop_lvl_d & ~w_stop_lvl;

    always_comb begin
        w_state_nxt = r_state;
        w_set       = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (w_start_stb && !w_stop_stb && w_door_ok && !timer_done) begin
                    w_state_nxt = ST_ON;
                    w_set       = 1'b1;
                end
            end
            ST_ON: begin
                if (w_stop_stb || !w_door_ok || timer_done) begin
                    w_state_nxt = ST_GUARD;
                    w_clr       = 1'b1;
                end
            end
            ST_GUARD: begin
                if (r_guard_cnt == GUARD_LAST) begin
                    w_state_nxt = ST_OFF;
                end
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    // The guard count is 0 in the R cycle, so GUARD spans exactly GUARD_CYCLES cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_lvl_d <= 1'b1;
            r_stop_lvl_d  <= 1'b1;
            r_state       <= ST_OFF;
            r_guard_cnt   <= '0;
            r_s           <= 1'b0;
            r_r           <= 1'b0;
            r_mag_on      <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_start_lvl_d <= w_start_lvl;
            r_stop_lvl_d  <= w_stop_lvl;
            r_state       <= w_state_nxt;
            r_guard_cnt   <= (r_state == ST_GUARD && w_state_nxt == ST_GUARD) ?
                             r_guard_cnt + 1'b1 : '0;
            r_s           <= w_set;
            r_r           <= w_clr;
            r_mag_on      <= (w_state_nxt == ST_ON);
            r_busy        <= (w_state_nxt != ST_OFF);
        end
    end

    assign S           = r_s;
    assign R           = r_r;
    assign mag_on      = r_mag_on;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mag_sr_driver.sv
// Bench for mag_sr_driver: directed scenarios with literal timing expectations plus
// randomized button/door/timer traffic compared every cycle against a behavioural model.
module tb_mag_sr_driver;
    import mag_pkg::*;

    localparam int DEB   = 4;
    localparam int GUARD = 8;

    // ---------------- clock / reset / DUT ----------------
    logic clk         = 1'b0;
    logic reset_n     = 1'b0;
    logic startn      = 1'b1;
    logic stopn       = 1'b1;
    logic door_closed = 1'b0;
    logic timer_done  = 1'b0;
    logic S, R, mag_on, busy;
    mag_state_e dbg_state;

    always #5 clk = ~clk;

    mag_sr_driver #(.DEB_CYCLES(DEB), .GUARD_CYCLES(GUARD)) dut (
        .clk(clk), .reset_n(reset_n), .startn(startn), .stopn(stopn),
        .door_closed(door_closed), .timer_done(timer_done),
        .S(S), .R(R), .mag_on(mag_on), .busy(busy), .o_dbg_state(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks    = 0;
    int n_pass      = 0;
    int cyc         = 0;
    int s_count     = 0;
    int r_count     = 0;
    int last_s_edge = -1;
    int last_r_edge = -1000;
    logic prev_on   = 1'b0;
    logic prev_rst  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    // Raw input histories, newest sample in bit 0; the logic sees raw@(k-2) at edge k.
    logic [15:0] h_start, h_stop, h_door;
    logic m_start_lvl, m_start_lvl_d, m_stop_lvl, m_stop_lvl_d, m_door_ok, m_on;
    int   m_last_r;
    logic [5:0] exp_q[$];

    function automatic bit win_all(input logic [15:0] h, input logic v);
        bit ok = 1'b1;
        for (int i = 0; i < DEB; i++) if (h[2+i] !== v) ok = 1'b0;
        return ok;
    endfunction

    always begin
        logic start_stb, stop_stb, e_s, e_r, e_on, e_busy;
        logic [1:0] e_st;
        logic [5:0] e;
        @(posedge clk);
        cyc++;
        e_s = 1'b0;
        e_r = 1'b0;
        if (!reset_n) begin
            h_start = '1; h_stop = '1; h_door = '0;
            m_start_lvl = 1'b1; m_start_lvl_d = 1'b1;
            m_stop_lvl = 1'b1;  m_stop_lvl_d = 1'b1;
            m_door_ok = 1'b0;   m_on = 1'b0;
            m_last_r = cyc - 100;
        end else begin
            start_stb = m_start_lvl_d && !m_start_lvl;
            stop_stb  = m_stop_lvl_d && !m_stop_lvl;
            if (m_on) begin
                if (stop_stb || !m_door_ok || timer_done) begin
                    m_on = 1'b0; e_r = 1'b1; m_last_r = cyc;
                end
            end else if ((cyc - 1 - m_last_r) >= GUARD && start_stb && !stop_stb &&
                         m_door_ok && !timer_done) begin
                m_on = 1'b1; e_s = 1'b1;
            end
            h_start = {h_start[14:0], startn};
            h_stop  = {h_stop[14:0], stopn};
            h_door  = {h_door[14:0], door_closed};
            m_start_lvl_d = m_start_lvl;
            if (win_all(h_start, !m_start_lvl)) m_start_lvl = !m_start_lvl;
            m_stop_lvl_d = m_stop_lvl;
            if (win_all(h_stop, !m_stop_lvl)) m_stop_lvl = !m_stop_lvl;
            if (!h_door[2]) m_door_ok = 1'b0;
            else if (win_all(h_door, 1'b1)) m_door_ok = 1'b1;
        end
        e_on   = m_on;
        e_busy = m_on || ((cyc - m_last_r) < GUARD);
        e_st   = m_on ? 2'd1 : (e_busy ? 2'd2 : 2'd0);
        exp_q.push_back({e_s, e_r, e_on, e_busy, e_st});

        #1;
        e = exp_q.pop_front();
        check("S", S, e[5]);
        check("R", R, e[4]);
        check("mag_on", mag_on, e[3]);
        check("busy", busy, e[2]);
        check("state", dbg_state, e[1:0]);
        check("s_r_exclusive", S & R, 0);
        if (reset_n && prev_rst && (mag_on !== prev_on)) check("mag_on_toggle_has_pulse", S | R, 1);
        if (S === 1'b1) check("s_after_r_spacing", (cyc - last_r_edge) > GUARD, 1);
        if (S === 1'b1) begin s_count++; last_s_edge = cyc; end
        if (R === 1'b1) begin r_count++; last_r_edge = cyc; end
        prev_on  = mag_on;
        prev_rst = reset_n;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic to_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic start_and_release();
        startn = 1'b0;
        wait_cycles(10);
        startn = 1'b1;
        wait_cycles(8);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int p, n, t, s0, r0;

        door_closed = 1'b1;
        reset_n     = 1'b0;
        wait_cycles(3);
        check("reset_outputs", {S, R, mag_on, busy}, 0);
        reset_n = 1'b1;
        wait_cycles(10);
        check("idle_after_reset", {S, R, mag_on, busy}, 0);

        // Start: S lands 2 sync + DEB debounce edges after the first sample, i.e. edge p+6.
        s0 = s_count;
        p = cyc + 1;
        startn = 1'b0;
        wait_cycles(8);
        check("start_latency", last_s_edge, p + 6);
        check("on_after_start", mag_on, 1);
        wait_cycles(50);
        check("held_start_one_strobe", s_count - s0, 1);
        startn = 1'b1;
        wait_cycles(8);

        // Door open while ON: R at n+3, GUARD covers edges n+3..n+10.
        s0 = s_count;
        n = cyc + 1;
        door_closed = 1'b0;
        wait_cycles(2);
        startn = 1'b0;
        to_edge(n + 10);
        check("door_r_latency", last_r_edge, n + 3);
        check("door_off", mag_on, 0);
        check("guard_last_cycle", busy, 1);
        to_edge(n + 11);
        check("guard_over", busy, 0);
        startn = 1'b1;
        wait_cycles(8);
        startn = 1'b0;
        wait_cycles(12);
        check("door_open_no_start", s_count - s0, 0);
        startn = 1'b1;
        door_closed = 1'b1;
        wait_cycles(10);

        // Simultaneous start and stop in OFF, then a short start glitch.
        s0 = s_count;
        r0 = r_count;
        startn = 1'b0;
        stopn  = 1'b0;
        wait_cycles(12);
        check("both_no_s", s_count - s0, 0);
        check("both_no_r", r_count - r0, 0);
        check("both_state_off", dbg_state, 0);
        startn = 1'b1;
        stopn  = 1'b1;
        wait_cycles(8);
        startn = 1'b0;
        wait_cycles(3);
        startn = 1'b1;
        wait_cycles(12);
        check("glitch_no_s", s_count - s0, 0);

        // Timer expiry while ON, then start attempt with timer_done held high.
        start_and_release();
        check("on_before_timer", mag_on, 1);
        t = cyc + 1;
        timer_done = 1'b1;
        wait_cycles(1);
        timer_done = 1'b0;
        wait_cycles(1);
        check("timer_r_latency", last_r_edge, t);
        check("timer_off", mag_on, 0);
        wait_cycles(12);
        s0 = s_count;
        timer_done = 1'b1;
        startn = 1'b0;
        wait_cycles(12);
        check("timer_blocks_start", s_count - s0, 0);
        startn = 1'b1;
        timer_done = 1'b0;
        wait_cycles(8);

        // Reset while ON: mag_on drops at once and no R is issued.
        start_and_release();
        check("on_before_reset", mag_on, 1);
        r0 = r_count;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("reset_mid_on", mag_on, 0);
        check("reset_mid_r", R, 0);
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(10);
        check("reset_no_r", r_count - r0, 0);

        // Random traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 999) < 60) startn = ~startn;
            if ($urandom_range(0, 999) < 25) stopn = ~stopn;
            if ($urandom_range(0, 999) < 12) door_closed = ~door_closed;
            timer_done = ($urandom_range(0, 999) < 15);
        end
        startn = 1'b1;
        stopn = 1'b1;
        timer_done = 1'b0;
        wait_cycles(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
